// File: rtl/gray_code_pkg.sv
// Shared definitions for the Gray-code counter family.
//   cnt_width : output/count width for a given modulus
//   bin2gray  : binary to reflected Gray (up to MaxWidth bits)
//   gray2bin  : reflected Gray back to binary (used by benches)
package gray_code_pkg;

    localparam int unsigned MaxWidth = 32;

    // Width of the count for a modulus of at least 2.
    function automatic int unsigned cnt_width(input int unsigned mod_value);
        return $clog2(mod_value);
    endfunction

    function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] gray);
        logic [MaxWidth-1:0] bin;
        bin[MaxWidth-1] = gray[MaxWidth-1];
        for (int i = MaxWidth - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_code_bin2gray.sv
// Combinational W-bit binary to reflected Gray converter.
//   bin_i  : binary input
//   gray_o : Gray-coded output, bin_i ^ (bin_i >> 1)
module gray_code_bin2gray #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_code_up_counter.sv
// Free-running modulo-MOD_VALUE up counter with a Gray-coded output.
// The binary count is the only state; the Gray output is decoded
// combinationally from it so it changes one bit per step (except at the
// wrap when MOD_VALUE is not a power of two).
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset, priority over counting
//   gray_count_out : current count in Gray code, width $clog2(MOD_VALUE)
// Optional macro GRAY_CNT_ASSERT_EN enables built-in concurrent assertions.
module gray_code_up_counter
    import gray_code_pkg::*;
#(
    parameter int unsigned MOD_VALUE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [cnt_width(MOD_VALUE)-1:0] gray_count_out
);

    localparam int unsigned W        = cnt_width(MOD_VALUE);
    localparam logic [W-1:0] MaxCount = W'(MOD_VALUE - 1);
    localparam bit          IsPow2   = ((MOD_VALUE & (MOD_VALUE - 1)) == 0);

    logic [W-1:0] count_binary;
    logic [W-1:0] count_binary_d;

    // Explicit compare covers non-power-of-two moduli; for powers of two it
    // matches natural overflow.
    always_comb begin
        count_binary_d = count_binary + W'(1);
        if (count_binary == MaxCount) begin
            count_binary_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_binary <= '0;
        end else begin
            count_binary <= count_binary_d;
        end
    end

    gray_code_bin2gray #(
        .W (W)
    ) u_bin2gray (
        .bin_i  (count_binary),
        .gray_o (gray_count_out)
    );

`ifdef GRAY_CNT_ASSERT_EN
    // Skip the first edge out of reset: the previous sample may predate reset.
    generate
        if (IsPow2) begin : g_onehot_chk
            a_one_bit_step : assert property (@(posedge clk) disable iff (rst)
                !$past(rst) |-> $onehot(gray_count_out ^ $past(gray_count_out)));
        end
    endgenerate

    a_in_range : assert property (@(posedge clk) disable iff (rst)
        count_binary <= MaxCount);

    a_zero_after_rst : assert property (@(posedge clk)
        rst |=> (gray_count_out == '0));
`else
    // Keeps IsPow2 referenced in the assertion-free build.
    logic unused_is_pow2;
    assign unused_is_pow2 = IsPow2;
`endif

endmodule

// File: tb/tb_gray_code_up_counter.sv
// Scoreboard bench for gray_code_up_counter at MOD_VALUE = 8, 16 and 6.
// The driver pushes hand-tabulated expected values per clock; a monitor
// pops and compares them on the following falling edge.
module tb_gray_code_up_counter;
    import gray_code_pkg::*;

    logic clk;
    logic rst;
    logic [2:0] gray8;
    logic [3:0] gray16;
    logic [2:0] gray6;

    gray_code_up_counter dut8 (
        .clk            (clk),
        .rst            (rst),
        .gray_count_out (gray8)
    );

    gray_code_up_counter #(
        .MOD_VALUE (16)
    ) dut16 (
        .clk            (clk),
        .rst            (rst),
        .gray_count_out (gray16)
    );

    gray_code_up_counter #(
        .MOD_VALUE (6)
    ) dut6 (
        .clk            (clk),
        .rst            (rst),
        .gray_count_out (gray6)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Hand-computed Gray sequences.
    localparam logic [2:0] G8  [8]  = '{3'b000, 3'b001, 3'b011, 3'b010,
                                        3'b110, 3'b111, 3'b101, 3'b100};
    localparam logic [3:0] G16 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                        4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                        4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                        4'b1010, 4'b1011, 4'b1001, 4'b1000};
    localparam logic [2:0] G6  [6]  = '{3'b000, 3'b001, 3'b011, 3'b010,
                                        3'b110, 3'b111};

    typedef struct {
        bit         step;
        logic [2:0] g8;
        logic [2:0] b8;
        logic [3:0] g16;
        logic [3:0] b16;
        logic [2:0] g6;
        logic [2:0] b6;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   k        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit r);
        exp_t e;
        if (r) k = 0;
        else   k++;
        e.step = !r;
        e.g8   = G8[k % 8];
        e.b8   = 3'(k % 8);
        e.g16  = G16[k % 16];
        e.b16  = 4'(k % 16);
        e.g6   = G6[k % 6];
        e.b6   = 3'(k % 6);
        exp_q.push_back(e);
    endtask

    // One clock with rst held at r across the next rising edge.
    task automatic cyc(input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 rst = r;
            push_exp(r);
        end
    endtask

    // rst pulse entirely inside the low phase: must not reset.
    task automatic short_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        push_exp(1'b0);
    endtask

    // Monitor
    initial begin : monitor
        exp_t       e;
        logic [2:0] prev8  = '0;
        logic [3:0] prev16 = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gray8",  32'(gray8),  32'(e.g8));
                chk("bin8",   32'(dut8.count_binary), 32'(e.b8));
                chk("gray16", 32'(gray16), 32'(e.g16));
                chk("bin16",  32'(dut16.count_binary), 32'(e.b16));
                chk("gray6",  32'(gray6),  32'(e.g6));
                chk("bin6",   32'(dut6.count_binary), 32'(e.b6));
                chk("gray2bin8", gray2bin(32'(gray8)), 32'(e.b8));
                if (e.step) begin
                    chk("onebit8",  32'($countones(gray8 ^ prev8)), 32'd1);
                    chk("onebit16", 32'($countones(gray16 ^ prev16)), 32'd1);
                end
                prev8  = gray8;
                prev16 = gray16;
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        cyc(1'b1, 2);     // reset for 2 edges
        cyc(1'b0, 17);    // through wrap of 6, 8 and 16 (incl. 1000 -> 0000)
        cyc(1'b0, 2);     // mod-8 count now binary 3 (Gray 010)
        cyc(1'b1, 5);     // mid-count reset held
        cyc(1'b0, 3);     // restart 001, 011, 010
        short_pulse();
        short_pulse();
        cyc(1'b0, 2);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
